// File: rtl/uart_tx_frame_if.sv
// Handshake bundle between the frame-dump address sequencer and uart_tx_frame.
// The sequencer is the master: it drives wen/data_in and consumes tx_tick.
interface uart_tx_frame_if;
    logic       wen;
    logic [7:0] data_in;
    logic       tx;
    logic       tx_tick;
    logic       busy;

    modport master (
        output wen,
        output data_in,
        input  tx,
        input  tx_tick,
        input  busy
    );

    modport slave (
        input  wen,
        input  data_in,
        output tx,
        output tx_tick,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART byte serializer for the 512x512 image dump path (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined); tx_tick tells the sequencer a frame is done.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_frame_if.slave   bus
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baudCnt_q, baudCnt_d;
    logic [3:0]    settleCnt_q, settleCnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          baudLast;

    assign baudLast = (baudCnt_q == BAUD_LAST);

    // State register plus registered outputs; tx must go idle-high on reset
    // without waiting for a clock so an abandoned frame never leaves a low line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            baudCnt_q   <= '0;
            settleCnt_q <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            settleCnt_q <= settleCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic. The baud counter only advances in the bit-carrying
    // states and is zeroed at every bit boundary and whenever it is idle.
    always_comb begin
        state_d     = state_q;
        baudCnt_d   = baudCnt_q;
        settleCnt_d = settleCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;

        case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                if (bus.wen) begin
                    state_d     = SETTLE;
                    settleCnt_d = '0;
                end
            end
            SETTLE: begin
                baudCnt_d = '0;
                if (settleCnt_q == SETTLE_LAST) begin
                    shift_d = bus.data_in;
                    state_d = START;
                end else begin
                    settleCnt_d = settleCnt_q + 4'd1;
                end
            end
            START: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q + BW'(1);
                end
            end
            DATA: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    state_d   = STOP;
                end else begin
                    baudCnt_d = baudCnt_q + BW'(1);
                end
            end
`endif
            STOP: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    baudCnt_d = baudCnt_q + BW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                baudCnt_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up exactly with the state they describe.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[bitIdx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = ^shift_d;
`endif
            default: tx_d = 1'b1;
        endcase
        tick_d = (state_d == STOP) && (baudCnt_d == BAUD_LAST);
        busy_d = (state_d != IDLE);
    end

    assign bus.tx      = tx_q;
    assign bus.tx_tick = tick_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at CLKS_PER_BIT=4, SETTLE_CYCLES=2; honours
// UART_TX_PARITY_EN when the bundle is built with it.
module tb_uart_tx_frame;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    vec_t vecs[7];

    uart_tx_frame_if bus();

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 10-unit clock; the bench samples and drives on falling edges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string nm, input logic actual, input logic expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b expected %b", nm, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wenV, input logic [7:0] dataV);
        bus.wen     = wenV;
        bus.data_in = dataV;
    endtask

    task automatic stepCheck(input string nm, input logic eTx, input logic eBusy, input logic eTick);
        @(negedge clk);
        checkOutput({nm, ".tx"}, bus.tx, eTx);
        checkOutput({nm, ".busy"}, bus.busy, eBusy);
        checkOutput({nm, ".tick"}, bus.tx_tick, eTick);
    endtask

    function automatic logic expBit(input logic [9:0] f, input logic par, input int b);
        logic r;
        r = f[b % 10];
`ifdef UART_TX_PARITY_EN
        if (b == 9)  r = par;
        if (b == 10) r = 1'b1;
`endif
        return r;
    endfunction

    // Checks frame cycles starting with the first start-bit cycle; data_in is
    // scrambled right after the latch point and wen optionally dropped.
    task automatic checkFrame(input string nm, input logic [9:0] f, input logic par,
                              input int dropIdx, input logic [7:0] afterData, input int stopAt);
        int n;
        n = (stopAt >= 0) ? stopAt : FB * CPB;
        for (int i = 0; i < n; i++) begin
            stepCheck($sformatf("%s[%0d]", nm, i), expBit(f, par, i / CPB), 1'b1,
                      i == FB * CPB - 1);
            if (i == 0) bus.data_in = afterData;
            if (i == dropIdx) bus.wen = 1'b0;
        end
    endtask

    task automatic idleCycles(input string nm, input int n);
        for (int i = 0; i < n; i++)
            stepCheck($sformatf("%s[%0d]", nm, i), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 8'h00);

        vecs[0] = '{data: 8'hA5, frame: 10'h34A, par: 1'b0};
        vecs[1] = '{data: 8'h00, frame: 10'h200, par: 1'b0};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE, par: 1'b0};
        vecs[3] = '{data: 8'h07, frame: 10'h20E, par: 1'b1};
        vecs[4] = '{data: 8'h03, frame: 10'h206, par: 1'b0};
        vecs[5] = '{data: 8'h80, frame: 10'h300, par: 1'b1};
        vecs[6] = '{data: 8'h01, frame: 10'h202, par: 1'b1};

        // Reset held for 3 cycles, then 100 idle cycles with wen low.
        for (int i = 0; i < 3; i++)
            stepCheck($sformatf("inReset[%0d]", i), 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        idleCycles("postReset", 100);

        // Single frames with wen pulsed for one cycle.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, ~vecs[k].data);
            stepCheck($sformatf("v%0d.settle0", k), 1'b1, 1'b1, 1'b0);
            bus.wen = 1'b0;
            stepCheck($sformatf("v%0d.settle1", k), 1'b1, 1'b1, 1'b0);
            bus.data_in = vecs[k].data;
            checkFrame($sformatf("v%0d", k), vecs[k].frame, vecs[k].par, -1,
                       ~vecs[k].data, -1);
            idleCycles($sformatf("v%0d.after", k), 4);
        end

        // Back-to-back with wen held: 0x00 then 0xFF, gap of one idle plus settle.
        applyStimulus(1'b1, 8'h00);
        stepCheck("b2b0.settle0", 1'b1, 1'b1, 1'b0);
        stepCheck("b2b0.settle1", 1'b1, 1'b1, 1'b0);
        checkFrame("b2b0", 10'h200, 1'b0, -1, 8'h00, -1);
        stepCheck("b2b.gapIdle", 1'b1, 1'b0, 1'b0);
        bus.data_in = 8'hFF;
        stepCheck("b2b1.settle0", 1'b1, 1'b1, 1'b0);
        stepCheck("b2b1.settle1", 1'b1, 1'b1, 1'b0);
        checkFrame("b2b1", 10'h3FE, 1'b0, 0, 8'hFF, -1);
        idleCycles("b2b.after", 10);

        // wen dropped 10 cycles after the start bit begins: frame still completes.
        applyStimulus(1'b1, 8'h5A);
        stepCheck("drop.settle0", 1'b1, 1'b1, 1'b0);
        stepCheck("drop.settle1", 1'b1, 1'b1, 1'b0);
        checkFrame("drop", 10'h2B4, 1'b0, 10, 8'h5A, -1);
        idleCycles("drop.after", 20);

        // Async reset between edges during data bit 3 of 0xA5 (tx low there).
        applyStimulus(1'b1, 8'hA5);
        stepCheck("rst.settle0", 1'b1, 1'b1, 1'b0);
        bus.wen = 1'b0;
        stepCheck("rst.settle1", 1'b1, 1'b1, 1'b0);
        checkFrame("rst.frame", 10'h34A, 1'b0, -1, 8'hA5, 18);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst.asyncTx", bus.tx, 1'b1);
        checkOutput("rst.asyncBusy", bus.busy, 1'b0);
        checkOutput("rst.asyncTick", bus.tx_tick, 1'b0);
        stepCheck("rst.held", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        idleCycles("rst.release", 10);
        applyStimulus(1'b1, 8'h00);
        stepCheck("clean.settle0", 1'b1, 1'b1, 1'b0);
        bus.wen = 1'b0;
        stepCheck("clean.settle1", 1'b1, 1'b1, 1'b0);
        bus.data_in = 8'h5A;
        checkFrame("clean", 10'h2B4, 1'b0, -1, 8'h00, -1);
        idleCycles("clean.after", 5);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
